// File: rtl/ibex_multdiv_iter_if.sv
// Bus bundle between ID/WB, the iterative mult/div unit and the shared ALU adder.
interface ibex_multdiv_iter_if;
    localparam int unsigned DATA_W = 32;

    logic                en_i;
    logic [2:0]          operator_i;
    logic [DATA_W-1:0]   op_a_i;
    logic [DATA_W-1:0]   op_b_i;
    logic [DATA_W:0]     alu_operand_a_o;
    logic [DATA_W:0]     alu_operand_b_o;
    logic                alu_sel_o;
    logic [DATA_W+1:0]   alu_adder_ext_i;
    logic                valid_o;
    logic [DATA_W-1:0]   result_o;

    // Requester side, which also closes the loop through the ALU adder.
    modport master (
        output en_i, operator_i, op_a_i, op_b_i, alu_adder_ext_i,
        input  alu_operand_a_o, alu_operand_b_o, alu_sel_o, valid_o, result_o
    );

    // The mult/div unit itself.
    modport slave (
        input  en_i, operator_i, op_a_i, op_b_i, alu_adder_ext_i,
        output alu_operand_a_o, alu_operand_b_o, alu_sel_o, valid_o, result_o
    );
endinterface

// File: rtl/ibex_multdiv_iter.sv
// Iterative 32-bit radix-2 shift-add multiplier / restoring divider sharing the ALU adder.
module ibex_multdiv_iter (
    input  logic               clk_i,
    input  logic               rst_i,
    ibex_multdiv_iter_if.slave bus
);
    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULHU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_REM   = 3'd4;
    localparam logic [2:0] OP_REMU  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ABS_A   = 3'd1,
        S_ABS_B   = 3'd2,
        S_ITER    = 3'd3,
        S_NEG_RES = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    function automatic logic f_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic f_is_signed(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic f_is_rem(input logic [2:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // r_hi is the multiply accumulator or the divide remainder; r_lo is the multiplier or
    // the dividend/quotient shift register; r_d is the multiplicand or divisor.
    state_e           r_state, w_state_nxt;
    logic [W-1:0]     r_hi, w_hi_nxt;
    logic [W-1:0]     r_lo, w_lo_nxt;
    logic [W-1:0]     r_d, w_d_nxt;
    logic [W-1:0]     r_result, w_result_nxt;
    logic [2:0]       r_op, w_op_nxt;
    logic             r_sign, w_sign_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic [W:0]       w_alu_a, w_alu_b;
    logic [W-1:0]     w_sum;
    logic             w_carry;
    logic [W-1:0]     w_shift;
    logic [W-1:0]     w_sel;
    logic [2:0]       w_in_op;
    logic             w_take;
    logic             w_unused_lsb;

    assign w_sum        = bus.alu_adder_ext_i[W:1];
    assign w_carry      = bus.alu_adder_ext_i[W+1];
    assign w_unused_lsb = bus.alu_adder_ext_i[0];
    assign w_shift      = {r_hi[W-2:0], r_lo[W-1]};
    assign w_sel        = f_is_rem(r_op) ? r_hi : r_lo;
    assign w_in_op      = (bus.operator_i > OP_REMU) ? OP_MUL : bus.operator_i;
    assign w_take       = r_hi[W-1] | w_carry;

    // Operand drive for the shared adder; zero whenever the unit is not busy.
    always_comb begin
        w_alu_a = '0;
        w_alu_b = '0;
        case (r_state)
            S_ABS_A: begin
                w_alu_a = {{W{1'b0}}, 1'b1};
                w_alu_b = {~r_lo, 1'b1};
            end
            S_ABS_B: begin
                w_alu_a = {{W{1'b0}}, 1'b1};
                w_alu_b = {~r_d, 1'b1};
            end
            S_ITER: begin
                if (f_is_div(r_op)) begin
                    w_alu_a = {w_shift, 1'b1};
                    w_alu_b = {~r_d, 1'b1};
                end else begin
                    w_alu_a = {r_hi, 1'b1};
                    w_alu_b = {(r_lo[0] ? r_d : {W{1'b0}}), 1'b0};
                end
            end
            S_NEG_RES: begin
                w_alu_a = {{W{1'b0}}, 1'b1};
                w_alu_b = {~w_sel, 1'b1};
            end
            default: ;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt  = r_state;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_d_nxt      = r_d;
        w_op_nxt     = r_op;
        w_sign_nxt   = r_sign;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        case (r_state)
            S_IDLE: begin
                if (bus.en_i) begin
                    w_op_nxt   = w_in_op;
                    w_hi_nxt   = '0;
                    w_sign_nxt = 1'b0;
                    w_cnt_nxt  = CNT_W'(W - 1);
                    if (f_is_div(w_in_op)) begin
                        w_lo_nxt = bus.op_a_i;
                        w_d_nxt  = bus.op_b_i;
                    end else begin
                        w_lo_nxt = bus.op_b_i;
                        w_d_nxt  = bus.op_a_i;
                    end
                    if (f_is_div(w_in_op) && (bus.op_b_i == '0)) begin
                        w_lo_nxt    = '1;
                        w_hi_nxt    = bus.op_a_i;
                        w_state_nxt = S_DONE;
                    end else if (f_is_signed(w_in_op)) begin
                        w_state_nxt = S_ABS_A;
                    end else begin
                        w_state_nxt = S_ITER;
                    end
                end
            end
            S_ABS_A: begin
                if (!bus.en_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    if (r_lo[W-1]) w_lo_nxt = w_sum;
                    w_sign_nxt  = f_is_rem(r_op) ? r_lo[W-1] : (r_lo[W-1] ^ r_d[W-1]);
                    w_state_nxt = S_ABS_B;
                end
            end
            S_ABS_B: begin
                if (!bus.en_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    if (r_d[W-1]) w_d_nxt = w_sum;
                    w_state_nxt = S_ITER;
                end
            end
            S_ITER: begin
                if (!bus.en_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    if (f_is_div(r_op)) begin
                        w_hi_nxt = w_take ? w_sum : w_shift;
                        w_lo_nxt = {r_lo[W-2:0], w_take};
                    end else begin
                        {w_hi_nxt, w_lo_nxt} = {w_carry, w_sum, r_lo[W-1:1]};
                    end
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        w_state_nxt = f_is_signed(r_op) ? S_NEG_RES : S_DONE;
                    end
                end
            end
            S_NEG_RES: begin
                if (!bus.en_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    if (r_sign) begin
                        if (f_is_rem(r_op)) w_hi_nxt = w_sum;
                        else                w_lo_nxt = w_sum;
                    end
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.en_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Capture the result on entry to DONE so result_o is a flop held through DONE.
        if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
            if ((w_op_nxt == OP_MULHU) || f_is_rem(w_op_nxt)) w_result_nxt = w_hi_nxt;
            else                                              w_result_nxt = w_lo_nxt;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_d      <= '0;
            r_result <= '0;
            r_op     <= '0;
            r_sign   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_d      <= w_d_nxt;
            r_result <= w_result_nxt;
            r_op     <= w_op_nxt;
            r_sign   <= w_sign_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign bus.alu_operand_a_o = w_alu_a;
    assign bus.alu_operand_b_o = w_alu_b;
    assign bus.alu_sel_o       = (r_state == S_ABS_A) || (r_state == S_ABS_B) ||
                                 (r_state == S_ITER)  || (r_state == S_NEG_RES);
    assign bus.valid_o         = (r_state == S_DONE);
    assign bus.result_o        = r_result;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed, table-driven bench for the iterative mult/div unit with an ALU adder model.
module tb_ibex_multdiv_iter;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    ibex_multdiv_iter_if bus ();

    ibex_multdiv_iter dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // ALU extended adder: zero-extended 33-bit operands summed to 34 bits.
    assign bus.alu_adder_ext_i = {1'b0, bus.alu_operand_a_o} + {1'b0, bus.alu_operand_b_o};

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.exp_res = exp_res; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endtask

    // Issue one operation, scramble inputs after accept, measure latency, check hold and release.
    task automatic run_vec(input vec_t v);
        int n;
        logic [31:0] res;
        @(negedge clk_i);
        bus.en_i = 1'b1; bus.operator_i = v.op; bus.op_a_i = v.a; bus.op_b_i = v.b;
        @(posedge clk_i); #1;
        n = 0;
        while (!bus.valid_o && n < 100) begin
            @(negedge clk_i);
            bus.operator_i = 3'($urandom); bus.op_a_i = $urandom; bus.op_b_i = $urandom;
            @(posedge clk_i); #1;
            n++;
        end
        check({v.name, " latency"}, 32'(n + 1), 32'(v.exp_lat));
        check({v.name, " result"}, bus.result_o, v.exp_res);
        res = bus.result_o;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_i); #1;
        end
        check({v.name, " valid held"}, 32'(bus.valid_o), 32'd1);
        check({v.name, " result held"}, bus.result_o, v.exp_res);
        @(negedge clk_i);
        bus.en_i = 1'b0;
        @(posedge clk_i); #1;
        check({v.name, " release"}, 32'({bus.valid_o, bus.alu_sel_o}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        bus.en_i = 1'b0; bus.operator_i = '0; bus.op_a_i = '0; bus.op_b_i = '0;

        add_vec("mul_7x6",        3'd0, 32'd7,        32'd6,        32'd42,       33);
        add_vec("mulhu_ffxff",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        add_vec("mul_ffxff",      3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
        add_vec("mulhu_8000x4",   3'd1, 32'h80000000, 32'd4,        32'd2,        33);
        add_vec("div_m7_2",       3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 36);
        add_vec("rem_m7_2",       3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 36);
        add_vec("div_7_m2",       3'd2, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 36);
        add_vec("rem_7_m2",       3'd4, 32'd7,        32'hFFFFFFFE, 32'd1,        36);
        add_vec("divu_5_0",       3'd3, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        add_vec("remu_5_0",       3'd5, 32'd5,        32'd0,        32'd5,        1);
        add_vec("rem_m7_0",       3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);
        add_vec("div_min_m1",     3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 36);
        add_vec("rem_min_m1",     3'd4, 32'h80000000, 32'hFFFFFFFF, 32'd0,        36);
        add_vec("divu_100_7",     3'd3, 32'd100,      32'd7,        32'd14,       33);
        add_vec("remu_100_7",     3'd5, 32'd100,      32'd7,        32'd2,        33);
        add_vec("divu_big",       3'd3, 32'hFFFFFFFF, 32'h80000001, 32'd1,        33);
        add_vec("remu_big",       3'd5, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33);
        add_vec("op7_as_mul",     3'd7, 32'd3,        32'd5,        32'd15,       33);

        // Reset state.
        repeat (3) @(posedge clk_i);
        #1;
        check("reset valid", 32'(bus.valid_o), 32'd0);
        check("reset alu_sel", 32'(bus.alu_sel_o), 32'd0);
        check("reset result", bus.result_o, 32'd0);
        check("reset operand_a", 32'(bus.alu_operand_a_o), 32'd0);
        check("reset operand_b", 32'(bus.alu_operand_b_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Abort a DIVU by dropping en_i at cycle 10.
        @(negedge clk_i);
        bus.en_i = 1'b1; bus.operator_i = 3'd3; bus.op_a_i = 32'd100; bus.op_b_i = 32'd7;
        @(posedge clk_i);
        repeat (9) @(posedge clk_i);
        #1;
        check("abort busy alu_sel", 32'(bus.alu_sel_o), 32'd1);
        @(negedge clk_i);
        bus.en_i = 1'b0;
        @(posedge clk_i); #1;
        check("abort alu_sel", 32'(bus.alu_sel_o), 32'd0);
        check("abort operand_b", 32'(bus.alu_operand_b_o), 32'd0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk_i); #1;
            if (bus.valid_o || bus.alu_sel_o) bad++;
        end
        check("abort stays idle", 32'(bad), 32'd0);

        // Reset mid-MUL with en_i still high.
        @(negedge clk_i);
        bus.en_i = 1'b1; bus.operator_i = 3'd0; bus.op_a_i = 32'd9; bus.op_b_i = 32'd9;
        @(posedge clk_i);
        repeat (5) @(posedge clk_i);
        #1;
        check("mul busy alu_sel", 32'(bus.alu_sel_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("midreset alu_sel", 32'(bus.alu_sel_o), 32'd0);
        check("midreset valid", 32'(bus.valid_o), 32'd0);
        check("midreset result", bus.result_o, 32'd0);
        check("midreset operand_a", 32'(bus.alu_operand_a_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0; bus.en_i = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk_i); #1;
            if (bus.valid_o || bus.alu_sel_o) bad++;
        end
        check("postreset idle", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
